// File: rtl/render_pkg.sv
// Shared constants, job-type and FSM encodings for the frame renderer.
package render_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    localparam logic [2:0] BLACK = 3'b000;
    localparam logic [2:0] WHITE = 3'b111;

    typedef enum logic [1:0] {
        JOB_DRAW  = 2'd0,
        JOB_ERASE = 2'd1,
        JOB_CLEAR = 2'd2
    } job_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLOT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Clear wins over erase, erase wins over draw.
    function automatic job_t pick_job(input logic clear_req, input logic erase_req);
        if (clear_req) begin
            return JOB_CLEAR;
        end else if (erase_req) begin
            return JOB_ERASE;
        end
        return JOB_DRAW;
    endfunction

endpackage

// File: rtl/xy_scan_counter.sv
// Raster-order 2D counter. dx/dy present the position the counter will hold
// after the coming edge, so the caller can register a pixel in the same cycle.
module xy_scan_counter (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] width,
    input  logic [6:0] height,
    input  logic       start,
    input  logic       enable,
    output logic [7:0] dx,
    output logic [6:0] dy,
    output logic       last
);

    logic [7:0] cnt_x_reg;
    logic [6:0] cnt_y_reg;
    logic       row_end;

    assign row_end = (cnt_x_reg == width - 8'd1);
    assign last    = row_end && (cnt_y_reg == height - 7'd1);

    always_comb begin
        dx = cnt_x_reg;
        dy = cnt_y_reg;
        if (start) begin
            dx = 8'd0;
            dy = 7'd0;
        end else if (enable) begin
            if (row_end) begin
                dx = 8'd0;
                dy = cnt_y_reg + 7'd1;
            end else begin
                dx = cnt_x_reg + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_x_reg <= 8'd0;
            cnt_y_reg <= 7'd0;
        end else begin
            cnt_x_reg <= dx;
            cnt_y_reg <= dy;
        end
    end

endmodule

// File: rtl/frame_renderer.sv
// Turns draw/erase/clear requests into one registered VGA pixel write per clock,
// clipping off-screen pixels while keeping a fixed width*height job length.
module frame_renderer
    import render_pkg::*;
#(
    parameter int BOX_W = 4,
    parameter int BOX_H = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       draw_req,
    input  logic       erase_req,
    input  logic       clear_req,
    input  logic [7:0] obj_x,
    input  logic [6:0] obj_y,
    input  logic [2:0] obj_colour,
    input  logic [2:0] bg_colour,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot,
    output logic       busy,
    output logic       done
);

    localparam logic [7:0] BOX_W_L = 8'(BOX_W);
    localparam logic [6:0] BOX_H_L = 7'(BOX_H);
    localparam logic [7:0] SCR_W_L = 8'(SCREEN_W);
    localparam logic [6:0] SCR_H_L = 7'(SCREEN_H);

    state_t     state_reg, state_next;
    logic [7:0] org_x_reg, org_x_next;
    logic [6:0] org_y_reg, org_y_next;
    logic [7:0] width_reg, width_next;
    logic [6:0] height_reg, height_next;
    logic [2:0] job_colour_reg, job_colour_next;

    logic [7:0] vga_x_reg, vga_x_next;
    logic [6:0] vga_y_reg, vga_y_next;
    logic [2:0] vga_colour_reg, vga_colour_next;
    logic       vga_plot_reg, vga_plot_next;
    logic       busy_reg, busy_next;
    logic       done_reg, done_next;

    logic       scan_start, scan_enable, scan_last;
    logic [7:0] scan_dx;
    logic [6:0] scan_dy;

    logic       any_req;
    job_t       job_sel;
    logic       emit;
    logic [7:0] pix_org_x;
    logic [6:0] pix_org_y;
    logic [2:0] pix_colour;
    logic [8:0] sum_x;
    logic [7:0] sum_y;

    assign any_req = clear_req | erase_req | draw_req;
    assign job_sel = pick_job(clear_req, erase_req);

    xy_scan_counter u_scan (
        .clk    (clk),
        .reset  (reset),
        .width  (width_reg),
        .height (height_reg),
        .start  (scan_start),
        .enable (scan_enable),
        .dx     (scan_dx),
        .dy     (scan_dy),
        .last   (scan_last)
    );

    // Control: state transitions, job latching and counter sequencing.
    always_comb begin
        state_next      = state_reg;
        org_x_next      = org_x_reg;
        org_y_next      = org_y_reg;
        width_next      = width_reg;
        height_next     = height_reg;
        job_colour_next = job_colour_reg;
        scan_start      = 1'b0;
        scan_enable     = 1'b0;
        emit            = 1'b0;
        done_next       = 1'b0;
        pix_org_x       = org_x_reg;
        pix_org_y       = org_y_reg;
        pix_colour      = job_colour_reg;

        case (state_reg)
            ST_IDLE: begin
                if (any_req) begin
                    case (job_sel)
                        JOB_CLEAR: begin
                            org_x_next      = 8'd0;
                            org_y_next      = 7'd0;
                            width_next      = SCR_W_L;
                            height_next     = SCR_H_L;
                            job_colour_next = bg_colour;
                        end
                        JOB_ERASE: begin
                            org_x_next      = obj_x;
                            org_y_next      = obj_y;
                            width_next      = BOX_W_L;
                            height_next     = BOX_H_L;
                            job_colour_next = bg_colour;
                        end
                        default: begin
                            org_x_next      = obj_x;
                            org_y_next      = obj_y;
                            width_next      = BOX_W_L;
                            height_next     = BOX_H_L;
                            job_colour_next = obj_colour;
                        end
                    endcase
                    // The first pixel is registered on the accepting edge itself.
                    pix_org_x  = org_x_next;
                    pix_org_y  = org_y_next;
                    pix_colour = job_colour_next;
                    scan_start = 1'b1;
                    emit       = 1'b1;
                    state_next = ST_PLOT;
                end
            end
            ST_PLOT: begin
                if (scan_last) begin
                    done_next  = 1'b1;
                    state_next = ST_DONE;
                end else begin
                    scan_enable = 1'b1;
                    emit        = 1'b1;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Datapath: one-bit-wider sums so wrapped coordinates are clipped, not aliased.
    always_comb begin
        sum_x           = {1'b0, pix_org_x} + {1'b0, scan_dx};
        sum_y           = {1'b0, pix_org_y} + {1'b0, scan_dy};
        vga_x_next      = 8'd0;
        vga_y_next      = 7'd0;
        vga_colour_next = 3'd0;
        vga_plot_next   = 1'b0;
        busy_next       = 1'b0;
        if (emit) begin
            vga_x_next      = sum_x[7:0];
            vga_y_next      = sum_y[6:0];
            vga_colour_next = pix_colour;
            vga_plot_next   = (sum_x < {1'b0, SCR_W_L}) && (sum_y < {1'b0, SCR_H_L});
            busy_next       = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            org_x_reg      <= 8'd0;
            org_y_reg      <= 7'd0;
            width_reg      <= 8'd0;
            height_reg     <= 7'd0;
            job_colour_reg <= 3'd0;
            vga_x_reg      <= 8'd0;
            vga_y_reg      <= 7'd0;
            vga_colour_reg <= 3'd0;
            vga_plot_reg   <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            org_x_reg      <= org_x_next;
            org_y_reg      <= org_y_next;
            width_reg      <= width_next;
            height_reg     <= height_next;
            job_colour_reg <= job_colour_next;
            vga_x_reg      <= vga_x_next;
            vga_y_reg      <= vga_y_next;
            vga_colour_reg <= vga_colour_next;
            vga_plot_reg   <= vga_plot_next;
            busy_reg       <= busy_next;
            done_reg       <= done_next;
        end
    end

    assign vga_x      = vga_x_reg;
    assign vga_y      = vga_y_reg;
    assign vga_colour = vga_colour_reg;
    assign vga_plot   = vga_plot_reg;
    assign busy       = busy_reg;
    assign done       = done_reg;

endmodule

// File: tb/tb_frame_renderer.sv
// Self-checking bench for frame_renderer: table of jobs plus hand-written
// busy-protection and mid-job reset sequences, pixels checked via scoreboard.
module tb_frame_renderer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       draw_req = 1'b0;
    logic       erase_req = 1'b0;
    logic       clear_req = 1'b0;
    logic [7:0] obj_x = 8'd0;
    logic [6:0] obj_y = 7'd0;
    logic [2:0] obj_colour = 3'd0;
    logic [2:0] bg_colour = 3'd0;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;
    logic       busy;
    logic       done;

    frame_renderer #(.BOX_W(4), .BOX_H(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .draw_req   (draw_req),
        .erase_req  (erase_req),
        .clear_req  (clear_req),
        .obj_x      (obj_x),
        .obj_y      (obj_y),
        .obj_colour (obj_colour),
        .bg_colour  (bg_colour),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
        logic       p;
    } pix_t;

    typedef struct {
        logic       clr;
        logic       ers;
        logic       drw;
        logic [7:0] ox;
        logic [6:0] oy;
        logic [2:0] oc;
        logic [2:0] bg;
        int         len;
        int         plots;
        logic [2:0] colour;
        string      name;
    } vec_t;

    pix_t sb_q[$];
    pix_t mon_e, mon_a;
    vec_t vecs[10];
    int   checks = 0;
    int   failures = 0;
    int   plot_count = 0;
    int   done_count = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Every busy cycle must match the next expected pixel in raster order.
    always @(negedge clk) begin
        if (!reset) begin
            if (busy) begin
                if (sb_q.size() == 0) begin
                    check("sb_underflow", 1, 0);
                end else begin
                    mon_e = sb_q.pop_front();
                    mon_a = {vga_x, vga_y, vga_colour, vga_plot};
                    check("pixel", int'(mon_a), int'(mon_e));
                end
            end else begin
                check("plot_when_idle", int'(vga_plot), 0);
            end
            if (vga_plot) plot_count++;
            if (done) done_count++;
        end
    end

    task automatic push_job(input logic clr, input logic ers, input logic [7:0] ox,
                            input logic [6:0] oy, input logic [2:0] oc, input logic [2:0] bg);
        int bx, by, w, h, sx, sy;
        logic [2:0] col;
        pix_t p;
        if (clr) begin
            bx = 0; by = 0; w = 160; h = 120; col = bg;
        end else if (ers) begin
            bx = int'(ox); by = int'(oy); w = 4; h = 4; col = bg;
        end else begin
            bx = int'(ox); by = int'(oy); w = 4; h = 4; col = oc;
        end
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                sx = bx + x;
                sy = by + y;
                p.x = sx[7:0];
                p.y = sy[6:0];
                p.c = col;
                p.p = (sx < 160) && (sy < 120);
                sb_q.push_back(p);
            end
        end
    endtask

    // Called just after a negedge; returns just after a negedge.
    task automatic run_job(input vec_t v);
        int c, done_c, p0;
        push_job(v.clr, v.ers, v.ox, v.oy, v.oc, v.bg);
        p0 = plot_count;
        clear_req = v.clr; erase_req = v.ers; draw_req = v.drw;
        obj_x = v.ox; obj_y = v.oy; obj_colour = v.oc; bg_colour = v.bg;
        c = 0;
        done_c = -1;
        while (c < v.len + 20 && done_c < 0) begin
            @(negedge clk);
            c++;
            if (c == 1) begin
                check({v.name, "_busy_first"}, int'(busy), 1);
                check({v.name, "_colour"}, int'(vga_colour), int'(v.colour));
                clear_req = 1'b0; erase_req = 1'b0; draw_req = 1'b0;
                obj_x = 8'($urandom); obj_y = 7'($urandom);
                obj_colour = 3'($urandom); bg_colour = 3'($urandom);
            end
            if (done) begin
                done_c = c;
                check({v.name, "_busy_at_done"}, int'(busy), 0);
            end
        end
        check({v.name, "_done_cycle"}, done_c, v.len + 1);
        @(negedge clk);
        check({v.name, "_plots"}, plot_count - p0, v.plots);
        check({v.name, "_sb_empty"}, sb_q.size(), 0);
        sb_q.delete();
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, d0, nd, done_c;
        vec_t rv;

        vecs[0] = '{1'b0, 1'b0, 1'b1, 8'd10,  7'd20,  3'b100, 3'b001, 16,    16,    3'b100, "draw_nominal"};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 8'd158, 7'd50,  3'b010, 3'b001, 16,    8,     3'b010, "clip_right"};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 8'd30,  7'd40,  3'b111, 3'b011, 16,    16,    3'b011, "erase"};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 8'd159, 7'd119, 3'b101, 3'b000, 16,    1,     3'b101, "corner"};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 8'd254, 7'd10,  3'b110, 3'b000, 16,    0,     3'b110, "wrap_x"};
        vecs[5] = '{1'b0, 1'b0, 1'b1, 8'd60,  7'd118, 3'b001, 3'b000, 16,    8,     3'b001, "clip_bottom"};
        vecs[6] = '{1'b1, 1'b0, 1'b0, 8'd77,  7'd33,  3'b111, 3'b000, 19200, 19200, 3'b000, "clear"};
        vecs[7] = '{1'b1, 1'b1, 1'b1, 8'd5,   7'd5,   3'b110, 3'b101, 19200, 19200, 3'b101, "all_three"};
        vecs[8] = '{1'b0, 1'b1, 1'b1, 8'd7,   7'd9,   3'b001, 3'b110, 16,    16,    3'b110, "erase_draw"};
        vecs[9] = '{1'b0, 1'b0, 1'b1, 8'd0,   7'd0,   3'b011, 3'b100, 16,    16,    3'b011, "origin"};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_vga_x", int'(vga_x), 0);
        check("rst_vga_y", int'(vga_y), 0);
        check("rst_colour", int'(vga_colour), 0);
        check("rst_plot", int'(vga_plot), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        #1 reset = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            run_job(vecs[i]);
            $display("job %s done", vecs[i].name);
        end

        // A second request while busy must be ignored.
        push_job(1'b0, 1'b0, 8'd0, 7'd0, 3'b010, 3'b000);
        nd = 0;
        done_c = -1;
        draw_req = 1'b1; obj_x = 8'd0; obj_y = 7'd0; obj_colour = 3'b010;
        for (c = 1; c <= 45; c++) begin
            @(negedge clk);
            if (c == 1) draw_req = 1'b0;
            if (c == 5) begin
                draw_req = 1'b1; obj_x = 8'd50; obj_y = 7'd50; obj_colour = 3'b111;
            end
            if (c == 6) draw_req = 1'b0;
            if (done) begin
                nd++;
                done_c = c;
            end
        end
        check("busy_prot_dones", nd, 1);
        check("busy_prot_done_cycle", done_c, 17);
        check("busy_prot_sb_empty", sb_q.size(), 0);
        sb_q.delete();
        $display("job busy_protection done");

        // Reset in the middle of a job aborts it without a done pulse.
        push_job(1'b0, 1'b0, 8'd20, 7'd30, 3'b111, 3'b000);
        d0 = done_count;
        draw_req = 1'b1; obj_x = 8'd20; obj_y = 7'd30; obj_colour = 3'b111;
        for (c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) draw_req = 1'b0;
        end
        #1 reset = 1'b1;
        @(negedge clk);
        check("midrst_plot", int'(vga_plot), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_done", int'(done), 0);
        check("midrst_vga_x", int'(vga_x), 0);
        check("midrst_sb_left", sb_q.size(), 8);
        sb_q.delete();
        #1 reset = 1'b0;
        repeat (25) @(negedge clk);
        check("midrst_no_done", done_count - d0, 0);
        $display("job reset_mid_job done");

        rv = '{1'b0, 1'b0, 1'b1, 8'd40, 7'd60, 3'b010, 3'b000, 16, 16, 3'b010, "after_reset"};
        run_job(rv);
        $display("job after_reset done");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
